cp_remove_pp: RTL

//  Streaming cyclic-prefix remover: discards LCP leading samples per OFDM symbol, forwards NFFT body samples.

---
 rtl/dcp_pkg.sv | 18 +
 rtl/dcp_pp_ram.sv | 37 +++
 rtl/cp_remove_pp.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcp_pkg.sv
// Shared defaults and types for the cyclic-prefix remover (cp_remove_pp).
// Optional statistics ports are enabled by defining DCP_STATS_EN.
package dcp_pkg;

    localparam int DW_DEF        = 16;
    localparam int NFFT_DEF      = 64;
    localparam int LCP_LONG_DEF  = 16;
    localparam int LCP_SHORT_DEF = 8;
    localparam int IDX_W         = $clog2(NFFT_DEF);
    localparam int CPW           = $clog2(LCP_LONG_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } wr_state_e;

endpackage

// File: rtl/dcp_pp_ram.sv
// Ping-pong body store: two banks of NFFT complex samples, one write port and
// one registered read port. Storage is not reset.
module dcp_pp_ram #(
    parameter int DW   = 16,
    parameter int NFFT = 64
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic                      i_wbank,
    input  logic [$clog2(NFFT)-1:0]   i_waddr,
    input  logic [2*DW-1:0]           i_wdata,
    input  logic                      i_re,
    input  logic                      i_rbank,
    input  logic [$clog2(NFFT)-1:0]   i_raddr,
    output logic [2*DW-1:0]           o_rdata
);

    logic [2*DW-1:0] r_mem [0:2*NFFT-1];
    logic [2*DW-1:0] r_rdata;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_wbank, i_waddr}] <= i_wdata;
        end
    end

    // Registered read port; data holds while i_re is low
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[{i_rbank, i_raddr}];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cp_remove_pp.sv
// Streaming cyclic-prefix remover with ping-pong body buffer.
// Define DCP_STATS_EN to add SYM_CNT_O / ABORT_CNT_O statistics ports.
module cp_remove_pp
    import dcp_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int NFFT      = NFFT_DEF,
    parameter int LCP_LONG  = LCP_LONG_DEF,
    parameter int LCP_SHORT = LCP_SHORT_DEF
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I_r,
    input  logic [DW-1:0] DAT_I_i,
    input  logic          din,
    output logic          RDY_O,
    input  logic          SOP_I,
    input  logic          CP_MODE_I,
    output logic [DW-1:0] DAT_O_r,
    output logic [DW-1:0] DAT_O_i,
    output logic          DVAL_O,
    input  logic          RDY_I,
    output logic          SOP_O,
    output logic          EOP_O,
    output logic          ERR_O
`ifdef DCP_STATS_EN
    ,
    output logic [15:0]   SYM_CNT_O,
    output logic [7:0]    ABORT_CNT_O
`endif
);

    localparam int AW = $clog2(NFFT);
    localparam int LW = $clog2(LCP_LONG + 1);
    localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] CNT_LAST = AW'(NFFT - 1);
    localparam logic [LW-1:0] LCP_L    = LW'(LCP_LONG);
    localparam logic [LW-1:0] LCP_S    = LW'(LCP_SHORT);
    localparam logic [LW-1:0] LCP_ONE  = {{(LW-1){1'b0}}, 1'b1};

    wr_state_e       r_state, w_state_nxt;
    logic [AW-1:0]   r_cnt, w_cnt_nxt;
    logic [LW-1:0]   r_lcp, w_lcp_nxt, w_lcp_sel;
    logic            r_wr_bank, r_err;
    logic [1:0]      r_full, w_full_nxt;
    logic            w_rdy, w_in_xfer, w_we, w_fill, w_abort;

    logic            r_rd_bank, r_iss_bank;
    logic [AW-1:0]   r_iss_cnt;
    logic            r_s1_vld, r_s1_sop, r_s1_eop;
    logic            r_dval, r_sop, r_eop;
    logic [DW-1:0]   r_dat_r, r_dat_i;
    logic [2*DW-1:0] w_rdata;
    logic            w_out_adv, w_rd_en, w_eop_xfer;

    assign w_lcp_sel = CP_MODE_I ? LCP_L : LCP_S;
    assign w_rdy     = (r_state != ST_BODY) || !r_full[r_wr_bank];
    // Gated by reset so ready is low in reset yet high in the very first cycle after release
    assign RDY_O     = w_rdy & RST_I;
    assign w_in_xfer = din & RDY_O;

    // Write FSM state register with counter, CP length, bank pointer and sticky error
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_lcp     <= LCP_S;
            r_wr_bank <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lcp     <= w_lcp_nxt;
            r_wr_bank <= r_wr_bank ^ w_fill;
            r_err     <= r_err | w_abort;
        end
    end

    // Write FSM next state: SOP always restarts a symbol, otherwise walk CP then body
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lcp_nxt   = r_lcp;
        if (w_in_xfer && SOP_I) begin
            w_lcp_nxt = w_lcp_sel;
            if (w_lcp_sel == LCP_ONE) begin
                w_state_nxt = ST_BODY;
                w_cnt_nxt   = CNT_ZERO;
            end else begin
                w_state_nxt = ST_CP;
                w_cnt_nxt   = CNT_ONE;
            end
        end else if (w_in_xfer) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_CP: begin
                    if (r_cnt == AW'(r_lcp - LCP_ONE)) begin
                        w_state_nxt = ST_BODY;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                ST_BODY: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_CP;
                        w_cnt_nxt   = CNT_ZERO;
                        w_lcp_nxt   = w_lcp_sel;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Write FSM outputs: RAM write, bank-complete and abort strobes
    always_comb begin
        w_we    = 1'b0;
        w_fill  = 1'b0;
        w_abort = 1'b0;
        if (w_in_xfer) begin
            w_abort = SOP_I && (r_state != ST_IDLE) && (r_cnt != CNT_ZERO);
            w_we    = !SOP_I && (r_state == ST_BODY);
            w_fill  = w_we && (r_cnt == CNT_LAST);
        end else begin
            w_abort = 1'b0;
        end
    end

    // Fill and free always target different banks, so both may land in one cycle
    always_comb begin
        w_full_nxt = r_full;
        if (w_eop_xfer) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end else begin
            w_full_nxt[r_rd_bank] = r_full[r_rd_bank];
        end
        if (w_fill) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end else begin
            w_full_nxt[r_wr_bank] = w_full_nxt[r_wr_bank];
        end
    end

    // Bank full flags
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    dcp_pp_ram #(.DW(DW), .NFFT(NFFT)) u_ram (
        .i_clk   (CLK_I),
        .i_we    (w_we),
        .i_wbank (r_wr_bank),
        .i_waddr (r_cnt),
        .i_wdata ({DAT_I_r, DAT_I_i}),
        .i_re    (w_rd_en),
        .i_rbank (r_iss_bank),
        .i_raddr (r_iss_cnt),
        .o_rdata (w_rdata)
    );

    // Issue runs ahead on its own bank pointer so the next bank streams without a gap
    assign w_out_adv  = !r_dval || RDY_I;
    assign w_rd_en    = r_full[r_iss_bank] && (!r_s1_vld || w_out_adv);
    assign w_eop_xfer = r_dval && RDY_I && r_eop;

    // Read issue counter and RAM-output stage tags
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_iss_bank <= 1'b0;
            r_iss_cnt  <= CNT_ZERO;
            r_s1_vld   <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_rd_bank  <= 1'b0;
        end else begin
            r_s1_vld  <= w_rd_en | (r_s1_vld & !w_out_adv);
            r_rd_bank <= r_rd_bank ^ w_eop_xfer;
            if (w_rd_en) begin
                r_s1_sop <= (r_iss_cnt == CNT_ZERO);
                r_s1_eop <= (r_iss_cnt == CNT_LAST);
                if (r_iss_cnt == CNT_LAST) begin
                    r_iss_cnt  <= CNT_ZERO;
                    r_iss_bank <= ~r_iss_bank;
                end else begin
                    r_iss_cnt  <= r_iss_cnt + CNT_ONE;
                end
            end
        end
    end

    // Output register: advances when empty or accepted, holds under backpressure
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_dval  <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_dat_r <= {DW{1'b0}};
            r_dat_i <= {DW{1'b0}};
        end else if (w_out_adv) begin
            r_dval <= r_s1_vld;
            r_sop  <= r_s1_vld & r_s1_sop;
            r_eop  <= r_s1_vld & r_s1_eop;
            if (r_s1_vld) begin
                r_dat_r <= w_rdata[2*DW-1:DW];
                r_dat_i <= w_rdata[DW-1:0];
            end
        end
    end

    assign DAT_O_r = r_dat_r;
    assign DAT_O_i = r_dat_i;
    assign DVAL_O  = r_dval;
    assign SOP_O   = r_sop;
    assign EOP_O   = r_eop;
    assign ERR_O   = r_err;

`ifdef DCP_STATS_EN
    logic [15:0] r_sym_cnt;
    logic [7:0]  r_abort_cnt;

    // Symbol counter wraps; abort counter saturates
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_sym_cnt   <= 16'd0;
            r_abort_cnt <= 8'd0;
        end else begin
            if (w_eop_xfer) begin
                r_sym_cnt <= r_sym_cnt + 16'd1;
            end
            if (w_abort && (r_abort_cnt != 8'hFF)) begin
                r_abort_cnt <= r_abort_cnt + 8'd1;
            end
        end
    end

    assign SYM_CNT_O   = r_sym_cnt;
    assign ABORT_CNT_O = r_abort_cnt;
`endif

endmodule
